// File: rtl/rb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rb_pkg                                                       |
// | Description : Types shared by ring_buffer users and the rb_credit_tx link  |
// |               transmitter. Holds the transmitter control-state encoding.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rb_pkg;

  // Transmitter control states: WAIT is a one-cycle settle after reset,
  // RUN accepts beats, DRAIN refuses new beats while credits come home.
  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctx_state_t;

endpackage : rb_pkg
`default_nettype wire

// File: rtl/rb_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rb_if                                                        |
// | Description : Valid/ready payload bus used in front of ring buffers.       |
// |   valid : producer has a beat                                              |
// |   ready : consumer can take a beat this cycle                              |
// |   data  : payload (data_t)                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface rb_if #(
  parameter type data_t = logic
);
  logic  valid;
  logic  ready;
  data_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface : rb_if
`default_nettype wire

// File: rtl/rb_credit_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rb_credit_cnt                                                |
// | Description : Saturating credit counter, starts full (DEPTH).              |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   dec        : consume one credit (caller guarantees credits != 0)         |
// |   inc        : one credit returned                                         |
// |   credits    : current count                                               |
// |   zero       : credits == 0                                                |
// |   full_home  : credits == DEPTH                                            |
// |   err        : sticky, a return arrived while already full                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rb_credit_cnt #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] credits,
  output logic          zero,
  output logic          full_home,
  output logic          err
);

  localparam logic [CW-1:0] c_full = CW'(DEPTH);
  localparam logic [CW-1:0] c_one  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= c_full;
      r_err <= 1'b0;
    end else begin
      // Simultaneous dec and inc cancel, so only the one-sided cases move.
      if (inc && !dec) begin
        if (r_cnt == c_full) begin
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + c_one;
        end
      end else if (dec && !inc && (r_cnt != '0)) begin
        r_cnt <= r_cnt - c_one;
      end
    end
  end

  assign credits   = r_cnt;
  assign zero      = (r_cnt == '0);
  assign full_home = (r_cnt == c_full);
  assign err       = r_err;

endmodule : rb_credit_cnt
`default_nettype wire

// File: rtl/rb_credit_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rb_credit_tx                                                 |
// | Description : Credit-based transmitter feeding a remote ring_buffer over   |
// |               a registered valid-only link.                                |
// |   clk, rst_n : clock, asynchronous active-low reset                        |
// |   i_bus      : upstream payload (rb_if slave)                              |
// |   tx_valid   : registered link beat valid                                  |
// |   tx_data    : registered link payload                                     |
// |   cred_ret   : one credit returned per high cycle                          |
// |   quiesce    : level, stop accepting new beats                             |
// |   idle       : quiesced and every credit home                              |
// |   credits    : current credit count                                        |
// |   credit_err : sticky, credit returned while already at DEPTH              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rb_credit_tx
  import rb_pkg::*;
#(
  parameter type data_t = logic,
  parameter int  DEPTH  = 16,
  parameter int  CW     = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  rb_if.slave           i_bus,
  output logic          tx_valid,
  output data_t         tx_data,
  input  logic          cred_ret,
  input  logic          quiesce,
  output logic          idle,
  output logic [CW-1:0] credits,
  output logic          credit_err
);

  ctx_state_t r_state;
  ctx_state_t w_state_nxt;
  logic       r_tx_valid;
  data_t      r_tx_data;
  logic       w_ready;
  logic       w_acc;
  logic       w_zero;
  logic       w_full_home;

  rb_credit_cnt #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .dec       (w_acc),
    .inc       (cred_ret),
    .credits   (credits),
    .zero      (w_zero),
    .full_home (w_full_home),
    .err       (credit_err)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT:    w_state_nxt = RUN;
      RUN:     if (quiesce)  w_state_nxt = DRAIN;
      DRAIN:   if (!quiesce) w_state_nxt = RUN;
      default: w_state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready comes only from registers, so a credit returned this cycle cannot
  // open the gate until the next cycle, and quiesce takes effect one cycle
  // late through the state register.
  assign w_ready     = (r_state == RUN) && !w_zero;
  assign w_acc       = i_bus.valid && w_ready;
  assign i_bus.ready = w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_tx_valid <= w_acc;
      if (w_acc) begin
        r_tx_data <= i_bus.data;
      end
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign idle     = (r_state == DRAIN) && w_full_home;

endmodule : rb_credit_tx
`default_nettype wire

// File: tb/tb_rb_credit_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rb_credit_tx                                              |
// | Description : Self-checking bench for rb_credit_tx (DEPTH=4, 8-bit data). |
// |               A cycle-level behavioural model is compared on every cycle; |
// |               directed sequences pin literal expectations.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rb_credit_tx;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  typedef logic [7:0] byte_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cred_ret = 1'b0;
  logic          quiesce = 1'b0;
  logic          tx_valid;
  byte_t         tx_data;
  logic          idle;
  logic [CW-1:0] credits;
  logic          credit_err;

  int n_checks = 0;
  int n_fail   = 0;

  rb_if #(.data_t(byte_t)) bus ();

  rb_credit_tx #(
    .data_t (byte_t),
    .DEPTH  (DEPTH),
    .CW     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_bus      (bus),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .cred_ret   (cred_ret),
    .quiesce    (quiesce),
    .idle       (idle),
    .credits    (credits),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Start of a new cycle: inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Outputs are observed on the falling edge, mid-cycle.
  task automatic smp();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: credits as a plain integer, the control state derived
  // from "cycles since reset" and "was quiesce high last cycle".
  // ---------------------------------------------------------------------------
  int    m_cred = DEPTH;
  int    m_cyc  = 0;
  bit    m_qprev, m_txv, m_err;
  byte_t m_txd;

  always @(negedge clk) begin
    bit e_drain, e_run, e_ready, e_idle, acc;
    if (!rst_n) begin
      m_cred = DEPTH; m_cyc = 0; m_qprev = 0;
      m_txv = 0; m_txd = '0; m_err = 0;
    end
    // First cycle after reset waits, second always runs, later cycles are
    // draining exactly when quiesce was high the cycle before.
    e_drain = (m_cyc >= 2) && m_qprev;
    e_run   = (m_cyc >= 1) && !e_drain;
    e_ready = e_run && (m_cred > 0);
    e_idle  = e_drain && (m_cred == DEPTH);

    chk("model_ready",    32'(bus.ready),  32'(e_ready));
    chk("model_tx_valid", 32'(tx_valid),   32'(m_txv));
    chk("model_tx_data",  32'(tx_data),    32'(m_txd));
    chk("model_credits",  32'(credits),    32'(m_cred));
    chk("model_err",      32'(credit_err), 32'(m_err));
    chk("model_idle",     32'(idle),       32'(e_idle));

    if (rst_n) begin
      acc   = bus.valid && e_ready;
      m_txv = acc;
      if (acc) m_txd = bus.data;
      m_cred = m_cred - int'(acc) + int'(cred_ret);
      if (m_cred > DEPTH) begin
        m_cred = DEPTH;
        m_err  = 1;
      end
      m_qprev = quiesce;
      m_cyc++;
    end
  end

  task automatic do_reset();
    cyc();
    rst_n = 1'b0; bus.valid = 1'b0; cred_ret = 1'b0; quiesce = 1'b0;
    cyc();
    rst_n = 1'b1;
    smp();
  endtask

  initial begin
    bus.valid = 1'b0;
    bus.data  = '0;

    // Burst of 4 with no credit returns.
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; bus.valid = 1'b1; bus.data = 8'hA0;
    smp();
    chk("wait_ready",  32'(bus.ready),  0);
    chk("rst_credits", 32'(credits),    4);
    chk("rst_txv",     32'(tx_valid),   0);
    chk("rst_txd",     32'(tx_data),    0);
    chk("rst_err",     32'(credit_err), 0);
    chk("rst_idle",    32'(idle),       0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("burst_ready", 32'(bus.ready), 1);
      chk("burst_txv",   32'(tx_valid), 32'(i > 0));
      if (i > 0) chk("burst_txd", 32'(tx_data), 32'(8'hA0 + i - 1));
      cyc();
      bus.data = byte_t'(8'hA0 + i + 1);
    end
    smp();
    chk("burst5_ready", 32'(bus.ready), 0);
    chk("burst_last",   32'(tx_data),   32'hA3);
    chk("burst_cred0",  32'(credits),   0);

    // Single credit at zero: ready waits a cycle, then exactly one beat.
    cyc(); cred_ret = 1'b1;
    smp();
    chk("zero_ret_ready", 32'(bus.ready), 0);
    chk("zero_ret_txv",   32'(tx_valid),  0);
    cyc(); cred_ret = 1'b0;
    smp();
    chk("ret_ready", 32'(bus.ready), 1);
    chk("ret_cred",  32'(credits),   1);
    cyc(); bus.data = 8'hA5;
    smp();
    chk("one_beat_txd",  32'(tx_data),   32'hA4);
    chk("one_beat_rdy",  32'(bus.ready), 0);
    cyc();
    smp();
    chk("one_beat_only", 32'(tx_valid), 0);

    // Back to 2 credits, then full rate with a return every cycle.
    cyc(); bus.valid = 1'b0; cred_ret = 1'b1;
    cyc();
    cyc(); bus.valid = 1'b1; bus.data = 8'hB0;
    for (int j = 0; j < 5; j++) begin
      smp();
      chk("steady_cred",  32'(credits),   2);
      chk("steady_ready", 32'(bus.ready), 1);
      if (j > 0) chk("steady_txd", 32'(tx_data), 32'(8'hB0 + j - 1));
      cyc();
      bus.data = byte_t'(8'hB0 + j + 1);
    end
    bus.valid = 1'b0; cred_ret = 1'b0;

    // Spurious return with every credit home.
    do_reset();
    cyc(); cred_ret = 1'b1;
    cyc(); cred_ret = 1'b0;
    smp();
    chk("spur_cred", 32'(credits),    4);
    chk("spur_err",  32'(credit_err), 1);
    repeat (3) cyc();
    smp();
    chk("err_sticky", 32'(credit_err), 1);
    do_reset();
    chk("err_cleared", 32'(credit_err), 0);

    // Quiesce with 3 outstanding, then bring them home.
    cyc(); bus.valid = 1'b1; bus.data = 8'hC0;
    cyc(); bus.data = 8'hC1;
    cyc(); bus.data = 8'hC2;
    cyc(); bus.valid = 1'b0; quiesce = 1'b1;
    smp();
    chk("q_cred1",  32'(credits),   1);
    chk("q_ready1", 32'(bus.ready), 1);
    cyc(); cred_ret = 1'b1;
    smp();
    chk("q_ready0", 32'(bus.ready), 0);
    cyc();
    cyc();
    smp();
    chk("q_not_idle", 32'(idle), 0);
    cyc(); cred_ret = 1'b0;
    smp();
    chk("q_idle", 32'(idle), 1);
    cyc(); quiesce = 1'b0;
    smp();
    chk("q_idle_hold", 32'(idle), 1);
    cyc();
    smp();
    chk("q_resume", 32'(bus.ready), 1);
    chk("q_idle0",  32'(idle),      0);

    // Asynchronous reset in the middle of a burst.
    cyc(); bus.valid = 1'b1; bus.data = 8'hD0;
    cyc(); bus.data = 8'hD1;
    cyc(); bus.data = 8'hD2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txv",   32'(tx_valid),  0);
    chk("mid_rst_cred",  32'(credits),   4);
    chk("mid_rst_ready", 32'(bus.ready), 0);
    cyc(); rst_n = 1'b1;
    smp();
    chk("rel_ready0", 32'(bus.ready), 0);
    cyc();
    smp();
    chk("rel_ready1", 32'(bus.ready), 1);

    // Randomized traffic, returns, quiesce toggles and occasional resets.
    for (int k = 0; k < 600; k++) begin
      cyc();
      rst_n     = ($urandom_range(0, 149) != 0);
      bus.valid = ($urandom_range(0, 3) != 0);
      bus.data  = byte_t'($urandom);
      cred_ret  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) quiesce = ~quiesce;
    end
    cyc();
    rst_n = 1'b1; bus.valid = 1'b0; cred_ret = 1'b0; quiesce = 1'b0;
    smp();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rb_credit_tx
`default_nettype wire
